// File: rtl/card_shoe_pkg.sv
// Shared blackjack definitions: shoe state encoding, deck size and the
// mapping from a raw LFSR word to a card value / ace flag.
package card_shoe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SETTLE,
    ST_READY,
    ST_EMPTY
  } shoe_state_t;

  localparam int         SHOE_DECK_SIZE = 12;
  localparam int         CARD_MOD       = 10;
  localparam logic [3:0] ACE_CODE       = 4'd0;
  localparam logic [3:0] LFSR_INIT      = 4'h1;

  typedef struct packed {
    logic [3:0] value;
    logic       ace;
  } card_t;

  // Raw 4-bit word to card: value 1..10, ace when the residue is the ace code.
  function automatic card_t card_map(input logic [3:0] q);
    logic [3:0] m;
    m = 4'(q % CARD_MOD);
    card_map.value = m + 4'd1;
    card_map.ace   = (m == ACE_CODE);
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// 4-bit Fibonacci LFSR card generator; a zero seed is promoted to 1 so the
// register can never lock up at zero.
module card_lfsr
  import card_shoe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] seed,
  input  logic       step,
  output logic [3:0] value,
  output logic       ace
);

  logic [3:0] q_reg;
  card_t      card;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= LFSR_INIT;
    end else if (load) begin
      q_reg <= (seed == 4'h0) ? LFSR_INIT : seed;
    end else if (step) begin
      q_reg <= {q_reg[2:0], q_reg[3] ^ q_reg[2]};
    end
  end

  assign card  = card_map(q_reg);
  assign value = card.value;
  assign ace   = card.ace;

endmodule

// File: rtl/card_shoe.sv
// Card shoe: fills a small deck from the LFSR on shuffle with fixed settle
// gaps, then deals one card per draw_req rising edge.
module card_shoe
  import card_shoe_pkg::*;
#(
  parameter int DECK_SIZE = SHOE_DECK_SIZE,
  parameter int FILL_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle,
  input  logic [3:0] seed,
  input  logic       draw_req,
  output logic       draw_ack,
  output logic [3:0] card_value,
  output logic       card_ace,
  output logic       draw_err,
  output logic       ready,
  output logic [3:0] cards_left
);

  localparam logic [3:0] LAST_IDX = 4'(DECK_SIZE - 1);
  localparam logic [7:0] GAP_LAST = 8'((FILL_GAP > 0) ? FILL_GAP - 1 : 0);

  shoe_state_t state_reg, state_next;

  logic [3:0] wr_ptr_reg;
  logic [3:0] rd_ptr_reg;
  logic [7:0] gap_cnt_reg;
  logic       draw_req_reg;
  logic       draw_rise;

  logic       fill_we;
  logic       lfsr_step;
  logic       do_ack;
  logic       do_err;
  logic [3:0] gen_value;
  logic       gen_ace;

  card_t deck [DECK_SIZE];

  card_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (shuffle),
    .seed  (seed),
    .step  (lfsr_step),
    .value (gen_value),
    .ace   (gen_ace)
  );

  assign draw_rise = draw_req & ~draw_req_reg;
  assign ready     = (state_reg == ST_READY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Shuffle outranks everything, including a coincident draw edge.
  always_comb begin
    state_next = state_reg;
    fill_we    = 1'b0;
    lfsr_step  = 1'b0;
    do_ack     = 1'b0;
    do_err     = 1'b0;
    if (shuffle) begin
      state_next = ST_FILL;
    end else begin
      case (state_reg)
        ST_IDLE: do_err = draw_rise;
        ST_FILL: begin
          fill_we   = 1'b1;
          lfsr_step = 1'b1;
          do_err    = draw_rise;
          if (wr_ptr_reg == LAST_IDX) state_next = ST_READY;
          else if (FILL_GAP == 0)     state_next = ST_FILL;
          else                        state_next = ST_SETTLE;
        end
        ST_SETTLE: begin
          lfsr_step = 1'b1;
          do_err    = draw_rise;
          if (gap_cnt_reg == GAP_LAST) state_next = ST_FILL;
        end
        ST_READY: begin
          do_ack = draw_rise;
          if (draw_rise && cards_left == 4'd1) state_next = ST_EMPTY;
        end
        ST_EMPTY: do_err = draw_rise;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= 4'd0;
      rd_ptr_reg   <= 4'd0;
      cards_left   <= 4'd0;
      gap_cnt_reg  <= 8'd0;
      draw_req_reg <= 1'b0;
      draw_ack     <= 1'b0;
      draw_err     <= 1'b0;
      card_value   <= 4'd0;
      card_ace     <= 1'b0;
    end else begin
      draw_req_reg <= draw_req;
      draw_ack     <= do_ack;
      draw_err     <= do_err;
      gap_cnt_reg  <= (state_reg == ST_SETTLE && !shuffle) ? gap_cnt_reg + 8'd1 : 8'd0;
      if (shuffle) begin
        wr_ptr_reg <= 4'd0;
        rd_ptr_reg <= 4'd0;
        cards_left <= 4'd0;
      end else if (fill_we) begin
        wr_ptr_reg <= wr_ptr_reg + 4'd1;
        cards_left <= cards_left + 4'd1;
      end else if (do_ack) begin
        rd_ptr_reg <= rd_ptr_reg + 4'd1;
        cards_left <= cards_left - 4'd1;
        card_value <= deck[rd_ptr_reg].value;
        card_ace   <= deck[rd_ptr_reg].ace;
      end
    end
  end

  // One register slot per card so the whole deck clears on reset.
  generate
    for (genvar gi = 0; gi < DECK_SIZE; gi++) begin : g_deck
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          deck[gi] <= '0;
        end else if (fill_we && wr_ptr_reg == 4'(gi)) begin
          deck[gi] <= '{value: gen_value, ace: gen_ace};
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe: directed scenarios plus randomized
// shuffle/draw rounds checked against an arithmetic model of the deck.
module tb_card_shoe;
  import card_shoe_pkg::*;

  localparam int DS = 12;
  localparam int FG = 2;
  localparam int READY_EDGE = 1 + (DS - 1) * (FG + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       shuffle = 1'b0;
  logic [3:0] seed = 4'd0;
  logic       draw_req = 1'b0;
  logic       draw_ack;
  logic [3:0] card_value;
  logic       card_ace;
  logic       draw_err;
  logic       ready;
  logic [3:0] cards_left;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_val [DS];
  int exp_ace [DS];
  int rd = 0;

  card_shoe #(.DECK_SIZE(DS), .FILL_GAP(FG)) dut (
    .clk        (clk),
    .rst        (rst),
    .shuffle    (shuffle),
    .seed       (seed),
    .draw_req   (draw_req),
    .draw_ack   (draw_ack),
    .card_value (card_value),
    .card_ace   (card_ace),
    .draw_err   (draw_err),
    .ready      (ready),
    .cards_left (cards_left)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: raw word sequence advances FG+1 times between consecutive cards.
  function automatic int lfsr_next(input int q);
    return ((q * 2) % 16) + (((q / 8) + (q / 4)) % 2);
  endfunction

  task automatic build_deck(input int s);
    int q;
    q = (s == 0) ? 1 : s;
    for (int k = 0; k < DS; k++) begin
      exp_val[k] = (q % 10) + 1;
      exp_ace[k] = ((q % 10) == 0) ? 1 : 0;
      for (int j = 0; j <= FG; j++) q = lfsr_next(q);
    end
    rd = 0;
  endtask

  task automatic do_shuffle(input int s);
    seed    = 4'(s);
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    build_deck(s);
  endtask

  task automatic wait_ready(input string tag, input int start);
    int n;
    n = start;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    check(tag, n, READY_EDGE);
    check({tag, "_left"}, cards_left, DS);
    $display("shuffle seed=%0d ready after edge %0d", seed, n);
  endtask

  task automatic draw_ok(input string tag);
    draw_req = 1'b1;
    tick();
    check({tag, "_ack"}, draw_ack, 1);
    check({tag, "_err"}, draw_err, 0);
    check({tag, "_val"}, card_value, exp_val[rd]);
    check({tag, "_ace"}, card_ace, exp_ace[rd]);
    check({tag, "_left"}, cards_left, DS - rd - 1);
    $display("draw %0d: value=%0d ace=%0d left=%0d", rd, card_value, card_ace, cards_left);
    draw_req = 1'b0;
    tick();
    check({tag, "_ackoff"}, draw_ack, 0);
    check({tag, "_hold"}, card_value, exp_val[rd]);
    rd++;
  endtask

  task automatic draw_bad(input string tag, input int exp_left);
    draw_req = 1'b1;
    tick();
    check({tag, "_err"}, draw_err, 1);
    check({tag, "_ack"}, draw_ack, 0);
    check({tag, "_left"}, cards_left, exp_left);
    $display("draw refused: err=%0d left=%0d", draw_err, cards_left);
    draw_req = 1'b0;
    tick();
    check({tag, "_erroff"}, draw_err, 0);
  endtask

  initial begin
    int acks;
    int rdy_seen;
    int nd;
    int s;

    // Reset state
    #1;
    check("rst_ready", ready, 0);
    check("rst_ack", draw_ack, 0);
    check("rst_err", draw_err, 0);
    check("rst_val", card_value, 0);
    check("rst_ace", card_ace, 0);
    check("rst_left", cards_left, 0);
    tick();
    rst = 1'b1;
    tick();

    draw_bad("idle_draw", 0);

    // Seed 1 fill with a refused draw partway through
    do_shuffle(1);
    tick();
    tick();
    draw_bad("fill_draw", 1);
    wait_ready("seed1_ready", 4);
    check("seed1_c0", exp_val[0], 2);

    draw_ok("d0");
    draw_ok("d1");
    draw_ok("d2");

    // Level held high yields a single ack
    draw_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      acks += int'(draw_ack);
    end
    draw_req = 1'b0;
    tick();
    check("hold_acks", acks, 1);
    check("hold_left", cards_left, DS - 4);
    check("hold_val", card_value, exp_val[3]);
    $display("held draw: acks=%0d left=%0d", acks, cards_left);
    rd = 4;

    while (rd < DS) draw_ok("dn");
    check("empty_state", 32'(dut.state_reg), 32'(ST_EMPTY));
    draw_bad("empty_draw", 0);
    check("empty_hold", card_value, exp_val[DS-1]);

    // Shuffle coincident with a draw edge in READY
    do_shuffle(1);
    wait_ready("seed1b_ready", 0);
    seed     = 4'd5;
    shuffle  = 1'b1;
    draw_req = 1'b1;
    tick();
    shuffle = 1'b0;
    check("shdr_ack", draw_ack, 0);
    check("shdr_err", draw_err, 0);
    check("shdr_left", cards_left, 0);
    check("shdr_state", 32'(dut.state_reg), 32'(ST_FILL));
    $display("shuffle+draw: ack=%0d err=%0d left=%0d", draw_ack, draw_err, cards_left);
    draw_req = 1'b0;
    build_deck(5);
    wait_ready("seed5_ready", 0);
    draw_ok("s5d0");

    // Reset at edge 10 of a fill, with draw_req held through it
    do_shuffle(3);
    repeat (9) tick();
    draw_req = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    #1;
    check("mrst_ready", ready, 0);
    check("mrst_ack", draw_ack, 0);
    check("mrst_err", draw_err, 0);
    check("mrst_val", card_value, 0);
    check("mrst_ace", card_ace, 0);
    check("mrst_left", cards_left, 0);
    check("mrst_state", 32'(dut.state_reg), 32'(ST_IDLE));
    tick();
    rst = 1'b1;
    acks = 0;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      acks += int'(draw_ack);
      rdy_seen += int'(ready);
    end
    draw_req = 1'b0;
    tick();
    check("mrst_noack", acks, 0);
    check("mrst_noready", rdy_seen, 0);
    $display("after reset: acks=%0d ready_cycles=%0d", acks, rdy_seen);

    // Randomized rounds, some with an aborted fill first
    for (int it = 0; it < 6; it++) begin
      s = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        do_shuffle($urandom_range(0, 15));
        repeat ($urandom_range(1, 20)) tick();
      end
      do_shuffle(s);
      wait_ready("rnd_ready", 0);
      nd = $urandom_range(1, DS);
      for (int k = 0; k < nd; k++) begin
        repeat ($urandom_range(0, 3)) tick();
        draw_ok("rnd");
      end
      if (nd == DS) begin
        check("rnd_empty", 32'(dut.state_reg), 32'(ST_EMPTY));
        draw_bad("rnd_over", 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
